instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with an IF/ID pipeline register.
//   clk, rst     : clock; asynchronous active-high reset
//   en           : 1 = advance, 0 = stall (everything holds)
//   flush        : redirect to branchTarget, inject BUBBLES NOP cycles
//   branchTarget : redirect address, used as given
//   imemAddr     : current PC (combinational) to instruction memory
//   imemData     : instruction at imemAddr, valid the same cycle
//   inst         : IF/ID instruction register (0 = bubble)
//   pcNext       : PC + PC_INC of the instruction held in inst
//   valid        : inst holds a real fetched instruction
//   fetchCount   : saturating count of valid instructions latched
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned BUBBLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] branchTarget,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic [31:0] pcNext,
  output logic        valid,
  output logic [31:0] fetchCount
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  localparam logic [31:0] INC      = 32'(PC_INC);
  localparam logic [2:0]  BUB_LOAD = 3'(BUBBLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [2:0]  bubble_q, bubble_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // The flush cycle itself is the first bubble, so REDIRECT is left on the
  // edge where the counter steps from 1 to 0.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = (BUBBLES == 1) ? RUN : REDIRECT;
    end else if (en) begin
      case (state_q)
        BOOT:     state_d = RUN;
        RUN:      state_d = RUN;
        REDIRECT: state_d = (bubble_q <= 3'd1) ? RUN : REDIRECT;
        default:  state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    count_d   = count_q;
    bubble_d  = bubble_q;
    if (flush) begin
      pc_d     = branchTarget;
      inst_d   = '0;
      valid_d  = 1'b0;
      bubble_d = BUB_LOAD;
    end else if (en) begin
      case (state_q)
        RUN: begin
          inst_d    = imemData;
          pc_next_d = pc_q + INC;
          pc_d      = pc_q + INC;
          valid_d   = 1'b1;
          if (count_q != '1) count_d = count_q + 32'd1;
        end
        REDIRECT: begin
          inst_d  = '0;
          valid_d = 1'b0;
          if (bubble_q != '0) bubble_d = bubble_q - 3'd1;
        end
        default: begin
          inst_d  = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      bubble_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      bubble_q  <= bubble_d;
    end
  end

  assign imemAddr   = pc_q;
  assign inst       = inst_q;
  assign pcNext     = pc_next_q;
  assign valid      = valid_q;
  assign fetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with BUBBLES=2.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr, imem_data, inst, pc_next, fetch_count;
  logic        valid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcn;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t obs[$];
  int   errors = 0;
  int   checks = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .PC_INC(4), .BUBBLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .branchTarget(branch_target),
    .imemAddr(imem_addr), .imemData(imem_data), .inst(inst), .pcNext(pc_next),
    .valid(valid), .fetchCount(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h204A_8000;
      32'h4:   return 32'h5698_000F;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always_comb imem_data = mem(imem_addr);

  function automatic exp_t observe();
    return '{inst: inst, pcn: pc_next, addr: imem_addr, valid: valid, cnt: fetch_count};
  endfunction

  function automatic exp_t mk(input logic [31:0] i, p, a, input logic v, input logic [31:0] c);
    return '{inst: i, pcn: p, addr: a, valid: v, cnt: c};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, capture what the DUT shows.
  task automatic step(input logic e, input logic f, input logic [31:0] t, input exp_t x);
    en = e; flush = f; branch_target = t;
    sb.push_back(x);
    @(posedge clk); #1;
    obs.push_back(observe());
  endtask

  task automatic test_reset;
    exp_t o;
    rst = 1'b0; en = 1'b1;
    #1 rst = 1'b1;
    #2;
    o = observe(); checks++;
    if (o !== mk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", o, mk(0, 0, 0, 0, 0));
    end
    repeat (2) @(posedge clk); #1;
    o = observe(); checks++;
    if (o !== mk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", o, mk(0, 0, 0, 0, 0));
    end
    rst = 1'b0;
  endtask

  task automatic test_boot(input string name);
    exp_t e, o;
    step(1, 0, 0, mk(0, 0, 0, 0, 0));
    step(1, 0, 0, mk(32'h204A_8000, 4, 4, 1, 1));
    step(1, 0, 0, mk(32'h5698_000F, 8, 8, 1, 2));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s[%0d] got=%h exp=%h", name, i, o, e); end
    end
  endtask

  task automatic test_stall;
    exp_t e, o;
    for (int k = 0; k < 3; k++) step(0, 0, 0, mk(32'h5698_000F, 8, 8, 1, 2));
    step(1, 0, 0, mk(mem(8), 32'hC, 32'hC, 1, 3));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_flush;
    exp_t e, o;
    step(1, 1, 32'h68, mk(0, 32'hC, 32'h68, 0, 3));
    step(1, 0, 0,      mk(0, 32'hC, 32'h68, 0, 3));
    step(1, 0, 0,      mk(mem(32'h68), 32'h6C, 32'h6C, 1, 4));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL flush[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_flush_restart;
    exp_t e, o;
    step(0, 1, 32'h200, mk(0, 32'h6C, 32'h200, 0, 4));
    step(0, 0, 0,       mk(0, 32'h6C, 32'h200, 0, 4));
    step(1, 1, 32'h100, mk(0, 32'h6C, 32'h100, 0, 4));
    step(1, 0, 0,       mk(0, 32'h6C, 32'h100, 0, 4));
    step(1, 0, 0,       mk(mem(32'h100), 32'h104, 32'h104, 1, 5));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL restart[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_wrap_saturate;
    exp_t e, o;
    step(1, 1, 32'hFFFF_FFFC, mk(0, 32'h104, 32'hFFFF_FFFC, 0, 5));
    step(1, 0, 0,             mk(0, 32'h104, 32'hFFFF_FFFC, 0, 5));
    step(1, 0, 0,             mk(mem(32'hFFFF_FFFC), 0, 0, 1, 6));
    en = 1'b0;
    force dut.count_q = 32'hFFFF_FFFD;
    #1 release dut.count_q;
    #1 checks++;
    if (fetch_count !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL count_preset got=%h exp=%h", fetch_count, 32'hFFFF_FFFD);
    end
    step(1, 0, 0, mk(32'h204A_8000, 4, 4, 1, 32'hFFFF_FFFE));
    step(1, 0, 0, mk(32'h5698_000F, 8, 8, 1, 32'hFFFF_FFFF));
    step(1, 0, 0, mk(mem(8), 32'hC, 32'hC, 1, 32'hFFFF_FFFF));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_sat[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_async_reset;
    exp_t e, o;
    step(1, 1, 32'h40, mk(0, 32'hC, 32'h40, 0, 32'hFFFF_FFFF));
    e = sb.pop_front(); o = obs.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL redirect_entry got=%h exp=%h", o, e); end
    #1 rst = 1'b1;
    #1;
    o = observe(); checks++;
    if (o !== mk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", o, mk(0, 0, 0, 0, 0));
    end
    #1 rst = 1'b0;
    test_boot("reboot");
  endtask

  initial begin
    test_reset();
    test_boot("boot");
    test_stall();
    test_flush();
    test_flush_restart();
    test_wrap_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
